// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: op codes, FSM encoding, flag indices.
// Divide ops are live only when SEQ_ALU_DIV_EN is defined.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADDU = 5'b0_0000;
  localparam logic [4:0] OP_SUBU = 5'b0_0001;
  localparam logic [4:0] OP_ADD  = 5'b0_0010;
  localparam logic [4:0] OP_SUB  = 5'b0_0011;
  localparam logic [4:0] OP_AND  = 5'b0_0100;
  localparam logic [4:0] OP_OR   = 5'b0_0101;
  localparam logic [4:0] OP_XOR  = 5'b0_0110;
  localparam logic [4:0] OP_NOR  = 5'b0_0111;
  localparam logic [4:0] OP_LUI  = 5'b0_1000;
  localparam logic [4:0] OP_SLTU = 5'b0_1010;
  localparam logic [4:0] OP_SLT  = 5'b0_1011;
  localparam logic [4:0] OP_SRA  = 5'b0_1100;
  localparam logic [4:0] OP_SRL  = 5'b0_1101;
  localparam logic [4:0] OP_SLL  = 5'b0_1110;
  localparam logic [4:0] OP_MULU = 5'b1_0000;
  localparam logic [4:0] OP_MUL  = 5'b1_0001;
  localparam logic [4:0] OP_DIVU = 5'b1_0010;
  localparam logic [4:0] OP_DIV  = 5'b1_0011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int F_ZERO  = 0;
  localparam int F_CARRY = 1;
  localparam int F_NEG   = 2;
  localparam int F_OVF   = 3;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier, one bit per cycle, on magnitudes.
// SEQ_ALU_DIV_EN adds a restoring divider sharing the same registers.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_sgn,
`ifdef SEQ_ALU_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;
  logic             r_negp;
  logic             r_sgn;

  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_hi_nx;
  logic [WIDTH-1:0]   w_lo_nx;
  logic [2*WIDTH-1:0] w_prod;

  assign w_ma = (i_sgn & i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mb = (i_sgn & i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_prod = r_negp ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign o_done = r_busy & (r_cnt == CNT_W'(WIDTH));

`ifdef SEQ_ALU_DIV_EN
  logic             r_div;
  logic             r_negr;
  logic             r_bz;
  logic             r_dovf;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_dif;

  assign w_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_dif = w_sh[WIDTH-1:0] - r_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= 1'b0;
      r_negr <= 1'b0;
      r_bz   <= 1'b0;
      r_dovf <= 1'b0;
      r_a    <= '0;
    end else if (i_start) begin
      r_div  <= i_div;
      r_negr <= i_sgn & i_a[WIDTH-1];
      r_bz   <= (i_b == '0);
      r_dovf <= i_sgn & (i_a == {1'b1, {(WIDTH-1){1'b0}}})
                & (i_b == '1);
      r_a    <= i_a;
    end
  end
`endif

  always_comb begin
    w_hi_nx = w_sum[WIDTH:1];
    w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    if (r_div) begin
      if (w_sh >= {1'b0, r_m}) begin
        w_hi_nx = w_dif;
        w_lo_nx = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nx = w_sh[WIDTH-1:0];
        w_lo_nx = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    o_lo  = w_prod[WIDTH-1:0];
    o_hi  = w_prod[2*WIDTH-1:WIDTH];
    o_ovf = r_sgn & (o_hi != {WIDTH{o_lo[WIDTH-1]}});
`ifdef SEQ_ALU_DIV_EN
    if (r_div) begin
      o_lo  = r_negp ? -r_lo : r_lo;
      o_hi  = r_negr ? -r_hi : r_hi;
      o_ovf = r_dovf;
      // x/0 reports the dividend back rather than the sign-fixed remainder
      if (r_bz) begin
        o_lo  = '1;
        o_hi  = r_a;
        o_ovf = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_m    <= '0;
      r_negp <= 1'b0;
      r_sgn  <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_negp <= i_sgn & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_sgn  <= i_sgn;
`ifdef SEQ_ALU_DIV_EN
      r_lo   <= i_div ? w_ma : w_mb;
      r_m    <= i_div ? w_mb : w_ma;
`else
      r_lo   <= w_mb;
      r_m    <= w_ma;
`endif
    end else if (r_busy) begin
      if (o_done) begin
        r_busy <= 1'b0;
      end else begin
        r_hi  <= w_hi_nx;
        r_lo  <= w_lo_nx;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: registered legacy ops plus iterative mul (div with
// SEQ_ALU_DIV_EN); results held until the consumer accepts them.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_rh;
  logic [3:0]       r_flags;
  logic             r_ill;

  logic               w_acc;
  logic               w_is_md;
  logic               w_ill;
  logic               w_nsel;
  logic               w_slt;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_sll;
  logic [WIDTH:0]     w_srl;
  logic [WIDTH:0]     w_sra;
  logic [WIDTH-1:0]   w_lr;
  logic [3:0]         w_lf;
  logic               w_md_done;
  logic               w_md_ovf;
  logic [WIDTH-1:0]   w_md_hi;
  logic [WIDTH-1:0]   w_md_lo;
  logic [3:0]         w_mf;

  assign in_ready = !rst & ((r_state == S_IDLE)
                  | ((r_state == S_DONE) & out_ready));
  assign w_acc = in_valid & in_ready;

  assign w_is_md = (aluc == OP_MULU) | (aluc == OP_MUL)
`ifdef SEQ_ALU_DIV_EN
                 | (aluc == OP_DIVU) | (aluc == OP_DIV)
`endif
                 ;
  assign w_ill = aluc[4] & !w_is_md;

  assign w_shamt = a[SHAMT_W-1:0];
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};
  assign w_slt = $signed(a) < $signed(b);
  // extra low/high bit captures the last bit shifted out
  assign w_sll = {1'b0, b} << w_shamt;
  assign w_srl = {b, 1'b0} >> w_shamt;
  assign w_sra = $signed({b, 1'b0}) >>> w_shamt;

  always_comb begin
    w_lr   = '0;
    w_lf   = '0;
    w_nsel = 1'b0;
    unique casez (aluc[3:0])
      4'b0000: begin
        w_lr = w_add[WIDTH-1:0];
        w_lf[F_CARRY] = w_add[WIDTH];
      end
      4'b0010: begin
        w_lr = w_add[WIDTH-1:0];
        w_lf[F_OVF] = (a[WIDTH-1] == b[WIDTH-1])
                    & (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        w_lr = w_sub[WIDTH-1:0];
        w_lf[F_CARRY] = w_sub[WIDTH];
      end
      4'b0011: begin
        w_lr = w_sub[WIDTH-1:0];
        w_lf[F_OVF] = (a[WIDTH-1] != b[WIDTH-1])
                    & (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0100: w_lr = a & b;
      4'b0101: w_lr = a | b;
      4'b0110: w_lr = a ^ b;
      4'b0111: w_lr = ~(a | b);
      4'b100?: w_lr = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b1011: begin
        w_lr = {{(WIDTH-1){1'b0}}, w_slt};
        w_nsel = 1'b1;
      end
      4'b1010: begin
        w_lr = {{(WIDTH-1){1'b0}}, w_sub[WIDTH]};
        w_lf[F_CARRY] = w_sub[WIDTH];
        w_nsel = 1'b1;
      end
      4'b1100: begin
        w_lr = w_sra[WIDTH:1];
        w_lf[F_CARRY] = w_sra[0];
      end
      4'b1101: begin
        w_lr = w_srl[WIDTH:1];
        w_lf[F_CARRY] = w_srl[0];
      end
      4'b111?: begin
        w_lr = w_sll[WIDTH-1:0];
        w_lf[F_CARRY] = w_sll[WIDTH];
      end
      default: ;
    endcase
    w_lf[F_ZERO] = (w_lr == '0);
    w_lf[F_NEG]  = w_nsel ? w_lr[0] : w_lr[WIDTH-1];
    if (aluc[4]) begin
      w_lr = '0;
      w_lf = '0;
    end
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_md (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_acc & w_is_md),
    .i_sgn   (aluc[0]),
`ifdef SEQ_ALU_DIV_EN
    .i_div   (aluc[1]),
`endif
    .i_a     (a),
    .i_b     (b),
    .o_done  (w_md_done),
    .o_hi    (w_md_hi),
    .o_lo    (w_md_lo),
    .o_ovf   (w_md_ovf)
  );

  always_comb begin
    w_mf = '0;
    w_mf[F_ZERO] = (w_md_lo == '0);
    w_mf[F_NEG]  = w_md_lo[WIDTH-1];
    w_mf[F_OVF]  = w_md_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_r     <= '0;
      r_rh    <= '0;
      r_flags <= '0;
      r_ill   <= 1'b0;
    end else if (w_acc && w_is_md) begin
      r_state <= S_BUSY;
    end else if (w_acc) begin
      r_state <= S_DONE;
      r_r     <= w_lr;
      r_rh    <= '0;
      r_flags <= w_lf;
      r_ill   <= w_ill;
    end else if (r_state == S_BUSY && w_md_done) begin
      r_state <= S_DONE;
      r_r     <= w_md_lo;
      r_rh    <= w_md_hi;
      r_flags <= w_mf;
      r_ill   <= 1'b0;
    end else if (r_state == S_DONE && out_ready) begin
      r_state <= S_IDLE;
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign r         = r_r;
  assign r_hi      = r_rh;
  assign zero      = r_flags[F_ZERO];
  assign carry     = r_flags[F_CARRY];
  assign negative  = r_flags[F_NEG];
  assign overflow  = r_flags[F_OVF];
  assign illegal   = r_ill;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=32.
// Divide vectors are selected by SEQ_ALU_DIV_EN.
module tb_seq_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   aluc;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic [W-1:0] r_hi;
  logic         zero;
  logic         carry;
  logic         negative;
  logic         overflow;
  logic         illegal;
  logic [3:0]   flags;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluc      (aluc),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .r_hi      (r_hi),
    .zero      (zero),
    .carry     (carry),
    .negative  (negative),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // flags packed as {zero, carry, negative, overflow}
  assign flags = {zero, carry, negative, overflow};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op1(input string tag, input logic [4:0] op,
                     input logic [W-1:0] va, input logic [W-1:0] vb,
                     input logic [W-1:0] er, input logic [3:0] ef,
                     input logic eill);
    aluc = op;
    a = va;
    b = vb;
    in_valid = 1'b1;
    #1 check({tag, ".rdy"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, ".vld"}, out_valid, 1);
    check({tag, ".r"}, r, er);
    check({tag, ".rhi"}, r_hi, 0);
    check({tag, ".flg"}, flags, ef);
    check({tag, ".ill"}, illegal, eill);
    tick;
    check({tag, ".drop"}, out_valid, 0);
  endtask

  // accepts a muldiv op, waits (bounded) for the result and checks it
  task automatic md_op(input string tag, input logic [4:0] op,
                       input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] erh, input logic [W-1:0] er,
                       input logic [3:0] ef);
    int cyc;
    int nrdy;
    aluc = op;
    a = va;
    b = vb;
    in_valid = 1'b1;
    #1 check({tag, ".rdy"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, ".busy"}, {in_ready, out_valid}, 0);
    cyc = 0;
    nrdy = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      tick;
      cyc++;
      if (out_valid !== 1'b1 && in_ready !== 1'b0) nrdy++;
    end
    check({tag, ".lat"}, cyc, W + 1);
    check({tag, ".rdylo"}, nrdy, 0);
    check({tag, ".r"}, r, er);
    check({tag, ".rhi"}, r_hi, erh);
    check({tag, ".flg"}, flags, ef);
    check({tag, ".ill"}, illegal, 0);
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    in_valid = 1'b0;
    aluc = '0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    tick;
    tick;
    check("rst.vld", out_valid, 0);
    check("rst.rdy", in_ready, 0);
    check("rst.r", {r_hi, r}, 0);
    check("rst.flg", {illegal, flags}, 0);
    rst = 1'b0;
    #1 check("rst.rel", in_ready, 1);
    tick;

    op1("addu", 5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1100, 0);
    op1("add", 5'b00010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0011, 0);
    op1("sub", 5'b00011, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0001, 0);
    op1("subu", 5'b00001, 32'h1, 32'h2, 32'hFFFFFFFF, 4'b0110, 0);
    op1("sll", 5'b01110, 32'h1F, 32'h0000FFFF, 32'h80000000, 4'b0110, 0);
    op1("slt", 5'b01011, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0010, 0);
    op1("sltu", 5'b01010, 32'h1, 32'h2, 32'h1, 4'b0110, 0);
    op1("sra", 5'b01100, 32'h4, 32'h8000001F, 32'hF8000001, 4'b0110, 0);
    op1("srl0", 5'b01101, 32'h20, 32'h5, 32'h5, 4'b0000, 0);
    op1("lui", 5'b01001, 32'hDEAD0000, 32'h00001234, 32'h12340000,
        4'b0000, 0);
    op1("nor", 5'b00111, 32'h0, 32'h0, 32'hFFFFFFFF, 4'b0010, 0);
    op1("xor", 5'b00110, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 4'b1000, 0);
    op1("undef", 5'b10100, 32'h5, 32'h6, 32'h0, 4'b0000, 1);
    op1("undef2", 5'b11011, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0000, 1);

    out_ready = 1'b0;
    md_op("mul", 5'b10001, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF,
          32'hFFFFFFF1, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("hold.vld", out_valid, 1);
      check("hold.rdy", in_ready, 0);
      check("hold.r", {r_hi, r}, 64'hFFFFFFFF_FFFFFFF1);
      check("hold.flg", flags, 4'b0010);
    end
    out_ready = 1'b1;
    md_op("b2b.mulu", 5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, 4'b0000);
    tick;
    md_op("mul.ovf", 5'b10001, 32'h00010000, 32'h00010000,
          32'h00000001, 32'h0, 4'b1001);
    tick;

    aluc = 5'b10001;
    a = 32'h5;
    b = 32'h6;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    check("abort.vld", out_valid, 0);
    check("abort.rdy", in_ready, 0);
    rst = 1'b0;
    #1 check("abort.rel", in_ready, 1);
    nv = 0;
    repeat (40) begin
      tick;
      if (out_valid !== 1'b0) nv++;
    end
    check("abort.none", nv, 0);
    op1("post", 5'b00000, 32'h2, 32'h3, 32'h5, 4'b0000, 0);

`ifdef SEQ_ALU_DIV_EN
    md_op("divu0", 5'b10010, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 4'b0011);
    tick;
    md_op("div", 5'b10011, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF,
          32'hFFFFFFFD, 4'b0010);
    tick;
    md_op("divmin", 5'b10011, 32'h80000000, 32'hFFFFFFFF, 32'h0,
          32'h80000000, 4'b0011);
    tick;
    md_op("divu", 5'b10010, 32'd100, 32'd7, 32'd2, 32'd14, 4'b0000);
    tick;
`else
    op1("nodiv", 5'b10010, 32'h7, 32'h0, 32'h0, 4'b0000, 1);
    op1("nodivs", 5'b10011, 32'h7, 32'h2, 32'h0, 4'b0000, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
